// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port 1K x 16 memory.
// Serialises port transactions, drives the memory strobes and returns read data with a one-cycle ack.
module mem_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 16,
    parameter int RD_LAT = 1      // legal range 1..7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr_en,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    // Handshake: a requester raises reqN (with weN/addrN/wdataN stable) and holds it
    // until ackN pulses for one cycle; reqN is only sampled while the FSM is in IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

    state_t     state;
    logic       last_grant;
    logic       grant;
    logic       lat_we;
    logic [2:0] wait_cnt;
    logic       pick;

    // On contention the port that did not win last time is chosen.
    always_comb begin
        pick = req1;
        if (req0 && req1) begin
            pick = ~last_grant;
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            lat_we      <= 1'b0;
            wait_cnt    <= 3'd0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            busy        <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant       <= pick;
                        last_grant  <= pick;
                        lat_we      <= pick ? we1 : we0;
                        mem_address <= pick ? addr1 : addr0;
                        mem_wdata   <= pick ? wdata1 : wdata0;
                        mem_wr_en   <= pick ? we1 : we0;
                        mem_rd      <= pick ? ~we1 : ~we0;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_wr_en <= 1'b0;
                    mem_rd    <= 1'b0;
                    if (lat_we) begin
                        ack0  <= ~grant;
                        ack1  <= grant;
                        state <= RESP;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        rdata <= mem_rdata;
                        ack0  <= ~grant;
                        ack1  <= grant;
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses RD_LAT=1, instance b uses RD_LAT=3,
// each attached to a small behavioural memory whose read data is valid only in the sample cycle.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance a (RD_LAT = 1)
    logic        req0_a, req1_a, we0_a, we1_a;
    logic [9:0]  addr0_a, addr1_a, maddr_a;
    logic [15:0] wdata0_a, wdata1_a, rdata_a, mwdata_a, mrdata_a;
    logic        ack0_a, ack1_a, busy_a, wr_a, rd_a;
    logic [1:0]  dbg_a;

    // Instance b (RD_LAT = 3)
    logic        req0_b, req1_b, we0_b, we1_b;
    logic [9:0]  addr0_b, addr1_b, maddr_b;
    logic [15:0] wdata0_b, wdata1_b, rdata_b, mwdata_b, mrdata_b;
    logic        ack0_b, ack1_b, busy_b, wr_b, rd_b;
    logic [1:0]  dbg_b;

    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [15:0] pl_data;

    mem_arbiter #(.AW(10), .DW(16), .RD_LAT(1)) u_a (
        .clk(clk), .reset(reset),
        .req0(req0_a), .req1(req1_a), .we0(we0_a), .we1(we1_a),
        .addr0(addr0_a), .addr1(addr1_a), .wdata0(wdata0_a), .wdata1(wdata1_a),
        .ack0(ack0_a), .ack1(ack1_a), .rdata(rdata_a), .busy(busy_a),
        .mem_address(maddr_a), .mem_wdata(mwdata_a), .mem_wr_en(wr_a), .mem_rd(rd_a),
        .mem_rdata(mrdata_a), .dbg_state(dbg_a)
    );

    mem_arbiter #(.AW(10), .DW(16), .RD_LAT(3)) u_b (
        .clk(clk), .reset(reset),
        .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
        .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
        .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .busy(busy_b),
        .mem_address(maddr_b), .mem_wdata(mwdata_b), .mem_wr_en(wr_b), .mem_rd(rd_b),
        .mem_rdata(mrdata_b), .dbg_state(dbg_b)
    );

    // Memory models: read data is 16'hDEAD except in the one cycle it is due.
    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];
    logic [15:0] pipe_b [3];

    always @(posedge clk) begin
        if (wr_a) mem_a[maddr_a] <= mwdata_a;
        mrdata_a <= rd_a ? mem_a[maddr_a] : 16'hDEAD;
    end

    always @(posedge clk) begin
        if (pl_en) mem_b[pl_addr] <= pl_data;
        else if (wr_b) mem_b[maddr_b] <= mwdata_b;
        pipe_b[0] <= rd_b ? mem_b[maddr_b] : 16'hDEAD;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mrdata_b = pipe_b[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0_a = 0; req1_a = 0; we0_a = 0; we1_a = 0;
        addr0_a = '0; addr1_a = '0; wdata0_a = '0; wdata1_a = '0;
        req0_b = 0; req1_b = 0; we0_b = 0; we1_b = 0;
        addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        step(); step(); step();
        reset = 1'b0;

        // Reset state and 5 idle cycles; preload word 0x155 of memory b meanwhile
        pl_en = 1'b1; pl_addr = 10'h155; pl_data = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            pl_en = 1'b0;
            chk("idle_ctl_a", 32'({busy_a, ack0_a, ack1_a, wr_a, rd_a}), 'h0);
            chk("idle_ctl_b", 32'({busy_b, ack0_b, ack1_b, wr_b, rd_b}), 'h0);
            chk("idle_addr_a", 32'(maddr_a), 'h0);
            chk("idle_addr_b", 32'(maddr_b), 'h0);
            chk("idle_data_a", {mwdata_a, rdata_a}, 'h0);
            chk("idle_data_b", {mwdata_b, rdata_b}, 'h0);
            chk("idle_state_a", 32'(dbg_a), 'h0);
        end

        // Port 0 write 0x3FF <- 0xBEEF, then read it back (RD_LAT=1)
        req0_a = 1; we0_a = 1; addr0_a = 10'h3FF; wdata0_a = 16'hBEEF;
        step();
        chk("wr_strobe", 32'({wr_a, rd_a, busy_a, ack0_a}), 'b1010);
        chk("wr_addr", 32'(maddr_a), 'h3FF);
        chk("wr_wdata", 32'(mwdata_a), 'hBEEF);
        step();
        chk("wr_ack", 32'({ack0_a, ack1_a, wr_a}), 'b100);
        req0_a = 0;
        step();
        chk("wr_ack_pulse", 32'({ack0_a, ack1_a, busy_a}), 'h0);
        req0_a = 1; we0_a = 0;
        step();
        chk("rd_strobe", 32'({rd_a, wr_a}), 'b10);
        chk("rd_addr", 32'(maddr_a), 'h3FF);
        step();
        chk("rd_wait", 32'({ack0_a, ack1_a, rd_a}), 'h0);
        step();
        chk("rd_ack", 32'({ack0_a, ack1_a}), 'b10);
        chk("rd_data", 32'(rdata_a), 'hBEEF);
        req0_a = 0;

        // Both ports request in the first cycle after reset; continuous contention
        reset = 1'b1;
        req0_a = 1; we0_a = 1; addr0_a = 10'h001; wdata0_a = 16'hA001;
        req1_a = 1; we1_a = 1; addr1_a = 10'h002; wdata1_a = 16'hB002;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("cont_wr", 32'(wr_a), 'h1);
            chk("cont_addr", 32'(maddr_a), (k % 2 == 1) ? 'h2 : 'h1);
            chk("cont_wdata", 32'(mwdata_a), (k % 2 == 1) ? 'hB002 : 'hA001);
            step();
            chk("cont_ack", 32'({ack0_a, ack1_a}), (k % 2 == 1) ? 'h1 : 'h2);
            if (k == 3) begin
                req0_a = 0;
                req1_a = 0;
            end
            step();
            chk("cont_idle", 32'({busy_a, ack0_a, ack1_a}), 'h0);
        end

        // Port 0 wins (port 1 was last); port 1 updates its request while waiting
        req0_a = 1; we0_a = 1; addr0_a = 10'h010; wdata0_a = 16'h1111;
        req1_a = 1; we1_a = 1; addr1_a = 10'h020; wdata1_a = 16'h2222;
        step();
        chk("chg_addr0", 32'(maddr_a), 'h010);
        chk("chg_wdata0", 32'(mwdata_a), 'h1111);
        addr1_a = 10'h021; wdata1_a = 16'h3333;
        step();
        chk("chg_ack0", 32'({ack0_a, ack1_a}), 'h2);
        req0_a = 0;
        step();
        chk("chg_idle", 32'(busy_a), 'h0);
        step();
        chk("chg_wr1", 32'(wr_a), 'h1);
        chk("chg_addr1", 32'(maddr_a), 'h021);
        chk("chg_wdata1", 32'(mwdata_a), 'h3333);
        step();
        chk("chg_ack1", 32'({ack0_a, ack1_a}), 'h1);
        req1_a = 0;
        step();
        req0_a = 1; we0_a = 0; addr0_a = 10'h010;
        step();
        chk("chg_rd_addr", 32'(maddr_a), 'h010);
        step();
        step();
        chk("chg_rd_ack", 32'(ack0_a), 'h1);
        chk("chg_rd_data", 32'(rdata_a), 'h1111);
        req0_a = 0;

        // RD_LAT=3: port 1 reads preloaded 0x155
        req1_b = 1; we1_b = 0; addr1_b = 10'h155;
        step();
        chk("l3_rd_strobe", 32'({rd_b, wr_b}), 'b10);
        chk("l3_rd_addr", 32'(maddr_b), 'h155);
        step();
        chk("l3_rd_pulse", 32'({rd_b, busy_b}), 'b01);
        step();
        step();
        chk("l3_no_early_ack", 32'({ack0_b, ack1_b}), 'h0);
        step();
        chk("l3_ack1", 32'({ack0_b, ack1_b}), 'h1);
        chk("l3_rdata", 32'(rdata_b), 'h1234);
        req1_b = 0;
        step();
        chk("l3_idle", 32'({busy_b, ack1_b}), 'h0);

        // A write must leave rdata alone
        req1_b = 1; we1_b = 1; wdata1_b = 16'h9999;
        step();
        chk("l3_wr_strobe", 32'({wr_b, rd_b}), 'b10);
        step();
        chk("l3_wr_ack", 32'(ack1_b), 'h1);
        chk("l3_rdata_hold", 32'(rdata_b), 'h1234);
        req1_b = 0;
        step();

        // Reset in WAIT drops the read; the held request restarts it after release
        req0_b = 1; we0_b = 0; addr0_b = 10'h155;
        step();
        chk("rst_rd_strobe", 32'(rd_b), 'h1);
        step();
        chk("rst_in_wait", 32'(busy_b), 'h1);
        reset = 1'b1;
        step();
        chk("rst_ctl", 32'({busy_b, ack0_b, ack1_b, wr_b, rd_b}), 'h0);
        chk("rst_addr", 32'(maddr_b), 'h0);
        chk("rst_rdata", 32'(rdata_b), 'h0);
        reset = 1'b0;
        step();
        chk("rst_restart", 32'(rd_b), 'h1);
        chk("rst_restart_addr", 32'(maddr_b), 'h155);
        step();
        step();
        step();
        chk("rst_no_early_ack", 32'(ack0_b), 'h0);
        step();
        chk("rst_ack0", 32'({ack0_b, ack1_b}), 'h2);
        chk("rst_rdata_new", 32'(rdata_b), 'h9999);
        req0_b = 0;
        step();
        chk("rst_end_idle", 32'({busy_b, ack0_b}), 'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
